cpu_divide: RTL and testbench

CPU_DIVIDE -- requirements
Module: cpu_divide

---
 rtl/cpu_divide.sv | 170 +++++++++++++++++
 tb/tb_cpu_divide.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_divide.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_divide
//  Description : Multi-cycle signed/unsigned integer divider. Radix-2
//                restoring iteration, one quotient bit per clock, followed
//                by a sign-fixup cycle. Fixed latency of WIDTH+2 clocks from
//                the accepting edge to o_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_divide #(
    parameter int WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_latch,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_numerator,
    input  logic [WIDTH-1:0] i_denominator,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_remainder
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,   // waiting for i_latch, outputs hold last result
        S_ITER  = 2'd1,   // one quotient bit per clock
        S_FIXUP = 2'd2,   // apply signs / divide-by-zero override
        S_DONE  = 2'd3    // raise o_ready
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_count;

    // Captured operation descriptors
    logic               r_signed;
    logic               r_num_sign;
    logic               r_den_sign;
    logic               r_den_zero;
    logic [WIDTH-1:0]   r_den_mag;

    // Working registers: r_quo starts as the numerator magnitude and is
    // shifted left while quotient bits fill in from the right; r_rem holds
    // the partial remainder.
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_rem;

    // ------------------------------------------------------------------------
    // Operand magnitudes at the latch edge. In unsigned mode the MSB is a
    // data bit, so no negation happens.
    // ------------------------------------------------------------------------
    logic             w_num_neg_in;
    logic             w_den_neg_in;
    logic [WIDTH-1:0] w_num_mag_in;
    logic [WIDTH-1:0] w_den_mag_in;

    assign w_num_neg_in = i_signed & i_numerator[WIDTH-1];
    assign w_den_neg_in = i_signed & i_denominator[WIDTH-1];
    assign w_num_mag_in = w_num_neg_in ? (~i_numerator + 1'b1)   : i_numerator;
    assign w_den_mag_in = w_den_neg_in ? (~i_denominator + 1'b1) : i_denominator;

    // ------------------------------------------------------------------------
    // One restoring-division step. The shifted remainder needs one extra bit
    // because it can reach 2*D-1. When the subtraction is taken the true
    // difference is below D, so the low WIDTH bits of the subtraction are
    // exact.
    // ------------------------------------------------------------------------
    logic [WIDTH:0]   w_shifted;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    assign w_shifted  = {r_rem, r_quo[WIDTH-1]};
    assign w_ge       = (w_shifted >= {1'b0, r_den_mag});
    assign w_sub      = w_shifted[WIDTH-1:0] - r_den_mag;
    assign w_rem_next = w_ge ? w_sub : w_shifted[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};

    // ------------------------------------------------------------------------
    // Sign fixup. The quotient is negative iff the operand signs differ; the
    // remainder follows the numerator. Division by zero forces an all-ones
    // quotient; the iteration already leaves |N| in the remainder (every step
    // subtracts zero), so re-applying the numerator sign returns N unchanged.
    // The most-negative / -1 case falls out naturally: magnitude 2^(W-1)
    // negated is itself.
    // ------------------------------------------------------------------------
    logic             w_num_neg;
    logic             w_quo_neg;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_num_neg = r_signed & r_num_sign;
    assign w_quo_neg = r_signed & (r_num_sign ^ r_den_sign);
    assign w_quo_fix = r_den_zero ? {WIDTH{1'b1}}
                     : (w_quo_neg ? (~r_quo + 1'b1) : r_quo);
    assign w_rem_fix = w_num_neg ? (~r_rem + 1'b1) : r_rem;

    // ------------------------------------------------------------------------
    // Control FSM and datapath registers; reset aborts any operation in flight
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_signed    <= 1'b0;
            r_num_sign  <= 1'b0;
            r_den_sign  <= 1'b0;
            r_den_zero  <= 1'b0;
            r_den_mag   <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            o_ready     <= 1'b1;
            o_result    <= '0;
            o_remainder <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_latch && o_ready) begin
                        r_signed   <= i_signed;
                        r_num_sign <= i_numerator[WIDTH-1];
                        r_den_sign <= i_denominator[WIDTH-1];
                        r_den_zero <= (i_denominator == '0);
                        r_den_mag  <= w_den_mag_in;
                        r_quo      <= w_num_mag_in;
                        r_rem      <= '0;
                        r_count    <= '0;
                        o_ready    <= 1'b0;
                        r_state    <= S_ITER;
                    end
                end

                S_ITER: begin
                    r_quo   <= w_quo_next;
                    r_rem   <= w_rem_next;
                    r_count <= r_count + 1'b1;
                    if (r_count == c_LAST) begin
                        r_state <= S_FIXUP;
                    end
                end

                S_FIXUP: begin
                    o_result    <= w_quo_fix;
                    o_remainder <= w_rem_fix;
                    r_state     <= S_DONE;
                end

                S_DONE: begin
                    o_ready <= 1'b1;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_divide.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_divide
//  Description : Self-checking bench for cpu_divide. Expected results are
//                queued at the accepting edge and popped when o_ready rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_divide;

    logic        i_clock = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_latch = 1'b0;
    logic        i_signed = 1'b0;
    logic [31:0] i_numerator = '0;
    logic [31:0] i_denominator = '0;
    logic        o_ready;
    logic [31:0] o_result;
    logic [31:0] o_remainder;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;

    cpu_divide #(.WIDTH(32)) dut (
        .i_clock       (i_clock),
        .i_reset_n     (i_reset_n),
        .i_latch       (i_latch),
        .i_signed      (i_signed),
        .i_numerator   (i_numerator),
        .i_denominator (i_denominator),
        .o_ready       (o_ready),
        .o_result      (o_result),
        .o_remainder   (o_remainder)
    );

    always #5 i_clock = ~i_clock;

    // Reference model of the division semantics
    function automatic exp_t model(input logic [31:0] n, input logic [31:0] d,
                                   input logic s);
        exp_t e;
        int   sn;
        int   sd;
        if (d == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = n;
        end else if (s) begin
            if (n == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
                e.q = 32'h8000_0000;
                e.r = 32'd0;
            end else begin
                sn  = n;
                sd  = d;
                e.q = sn / sd;
                e.r = sn % sd;
            end
        end else begin
            e.q = n / d;
            e.r = n % d;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive a latch strobe across the next rising edge; caller must be away
    // from the edge. Operands are scrambled afterwards.
    task automatic start_op(input logic [31:0] n, input logic [31:0] d,
                            input logic s, input bit push_exp);
        i_numerator   = n;
        i_denominator = d;
        i_signed      = s;
        i_latch       = 1'b1;
        @(posedge i_clock);
        #1;
        i_latch       = 1'b0;
        i_numerator   = $urandom;
        i_denominator = $urandom;
        i_signed      = 1'($urandom_range(0, 1));
        check("busy_after_latch", {31'd0, o_ready}, 32'd0);
        if (push_exp) sb.push_back(model(n, d, s));
    endtask

    // Count edges until o_ready; optionally pulse a stray latch at edge inject
    task automatic wait_done(input int inject);
        int   lat;
        exp_t e;
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge i_clock);
            if (k == inject) begin
                i_latch       = 1'b1;
                i_numerator   = 32'd9;
                i_denominator = 32'd3;
                i_signed      = 1'b0;
            end else begin
                i_latch = 1'b0;
            end
            @(posedge i_clock);
            #1;
            if (o_ready) begin
                lat = k;
                break;
            end
        end
        i_latch = 1'b0;
        check("latency", lat, 32'd34);
        if (lat != 0) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL scoreboard_empty: observed %0d expected >0", sb.size());
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                last_exp = e;
                check("quotient", o_result, e.q);
                check("remainder", o_remainder, e.r);
            end
        end
    endtask

    // Outputs must stay put while idle
    task automatic hold_check(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(posedge i_clock);
            #1;
            check("hold_ready", {31'd0, o_ready}, 32'd1);
            check("hold_quotient", o_result, last_exp.q);
            check("hold_remainder", o_remainder, last_exp.r);
        end
    endtask

    initial begin
        logic [31:0] rn;
        logic [31:0] rd;

        // Reset state
        repeat (2) @(posedge i_clock);
        #1;
        check("reset_ready", {31'd0, o_ready}, 32'd1);
        check("reset_result", o_result, 32'd0);
        check("reset_remainder", o_remainder, 32'd0);

        // First edge after release accepts the strobe
        @(negedge i_clock);
        i_reset_n = 1'b1;
        start_op(32'd100, 32'd7, 1'b0, 1'b1);
        wait_done(0);
        hold_check(3);

        // Back-to-back operations, signed and divide-by-zero corners
        start_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
        wait_done(0);
        start_op(32'd5, 32'd0, 1'b0, 1'b1);
        wait_done(0);
        start_op(32'd5, 32'd0, 1'b1, 1'b1);
        wait_done(0);
        start_op(32'hFFFF_FFFB, 32'd0, 1'b1, 1'b1);
        wait_done(0);
        start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
        wait_done(0);
        start_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
        wait_done(0);
        start_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1);
        wait_done(0);

        // Stray strobe while busy must be ignored
        start_op(32'd100, 32'd7, 1'b0, 1'b1);
        wait_done(10);

        // Random operands, alternating mode
        for (int i = 0; i < 6; i++) begin
            rn = $urandom;
            rd = $urandom >> $urandom_range(0, 31);
            start_op(rn, rd, 1'(i % 2), 1'b1);
            wait_done(0);
        end

        // Reset in the middle of an operation
        start_op(32'd1000, 32'd10, 1'b0, 1'b0);
        repeat (14) @(posedge i_clock);
        @(negedge i_clock);
        i_reset_n = 1'b0;
        #1;
        check("midop_reset_ready", {31'd0, o_ready}, 32'd1);
        check("midop_reset_result", o_result, 32'd0);
        check("midop_reset_remainder", o_remainder, 32'd0);
        i_latch       = 1'b1;
        i_numerator   = 32'd50;
        i_denominator = 32'd5;
        repeat (2) @(posedge i_clock);
        #1;
        check("latch_in_reset_ready", {31'd0, o_ready}, 32'd1);
        check("latch_in_reset_result", o_result, 32'd0);
        @(negedge i_clock);
        i_reset_n = 1'b1;
        start_op(32'd9, 32'd3, 1'b0, 1'b1);
        wait_done(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
